// File: rtl/pll_lock_sequencer.sv
// PLL lock qualifier and reset sequencer on the raw board clock. It drives the PLL RST input,
// filters the asynchronous LOCK and releases the downstream reset once the lock is trusted.
`timescale 1ns/1ps
module pll_lock_sequencer #(
   parameter int LOCK_FILTER    = 1024,
   parameter int RELEASE_DELAY  = 16,
   parameter int LOCK_TIMEOUT   = 25000,
   parameter int PLL_RST_CYCLES = 32,
   parameter int LOSS_W         = 8
) (
   input  logic              clkin,
   input  logic              reset_n,
   input  logic              locked,
   input  logic              soft_reset,
   output logic              pll_rst,
   output logic              sys_reset_n,
   output logic              ready,
   output logic [LOSS_W-1:0] lock_loss_count
);

   function automatic int max_of(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   localparam int MAX_COUNT = max_of(max_of(LOCK_FILTER, RELEASE_DELAY),
                                     max_of(LOCK_TIMEOUT, PLL_RST_CYCLES));
   localparam int CNT_W     = $clog2(MAX_COUNT) + 1;

   localparam logic [CNT_W-1:0]  CNT_ZERO     = CNT_W'(1'b0);
   localparam logic [CNT_W-1:0]  CNT_ONE      = CNT_W'(1'b1);
   localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 32'sd1);
   localparam logic [CNT_W-1:0]  PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 32'sd1);
   localparam logic [CNT_W-1:0]  FILTER_LAST  = CNT_W'(LOCK_FILTER - 32'sd1);
   localparam logic [CNT_W-1:0]  RELEASE_LAST = CNT_W'(RELEASE_DELAY - 32'sd1);
   localparam logic [LOSS_W-1:0] LOSS_ZERO    = LOSS_W'(1'b0);
   localparam logic [LOSS_W-1:0] LOSS_ONE     = LOSS_W'(1'b1);
   localparam logic [LOSS_W-1:0] LOSS_MAX     = {LOSS_W{1'b1}};

   function automatic logic [LOSS_W-1:0] sat_inc(input logic [LOSS_W-1:0] value);
      logic [LOSS_W-1:0] result;
      if (value == LOSS_MAX) begin
         result = value;
      end else begin
         result = value + LOSS_ONE;
      end
      return result;
   endfunction

   typedef enum logic [2:0] {
      ST_WAIT_LOCK = 3'd0,
      ST_PLL_RESET = 3'd1,
      ST_FILTER    = 3'd2,
      ST_RELEASE   = 3'd3,
      ST_RUN       = 3'd4
   } state_t;

   state_t            state_r;
   state_t            state_nxt_s;
   logic [CNT_W-1:0]  cnt_r;
   logic [CNT_W-1:0]  cnt_nxt_s;
   logic [LOSS_W-1:0] loss_cnt_r;
   logic [LOSS_W-1:0] loss_nxt_s;
   logic              lock_meta_r;
   logic              lock_sync_r;
   logic              locked_s;
   logic              pll_rst_r;
   logic              sys_reset_n_r;
   logic              ready_r;

   // Two-flop synchronizer for the PLL lock, which is asynchronous to clkin
   always_ff @(posedge clkin or negedge reset_n) begin
      if (!reset_n) begin
         lock_meta_r <= 1'b0;
         lock_sync_r <= 1'b0;
      end else begin
         lock_meta_r <= locked;
         lock_sync_r <= lock_meta_r;
      end
   end

   assign locked_s = lock_sync_r;

   // Next-state, phase counter and loss counter decode
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r + CNT_ONE;
      loss_nxt_s  = loss_cnt_r;
      case (state_r)
         ST_WAIT_LOCK: begin
            if (locked_s) begin
               state_nxt_s = ST_FILTER;
               cnt_nxt_s   = CNT_ZERO;
            end else if (cnt_r == TIMEOUT_LAST) begin
               state_nxt_s = ST_PLL_RESET;
               cnt_nxt_s   = CNT_ZERO;
            end else begin
               state_nxt_s = ST_WAIT_LOCK;
            end
         end
         ST_PLL_RESET: begin
            // the PLL's LOCK is meaningless while it is held in reset
            if (cnt_r == PLL_RST_LAST) begin
               state_nxt_s = ST_WAIT_LOCK;
               cnt_nxt_s   = CNT_ZERO;
            end else begin
               state_nxt_s = ST_PLL_RESET;
            end
         end
         ST_FILTER: begin
            if (!locked_s) begin
               state_nxt_s = ST_WAIT_LOCK;
               cnt_nxt_s   = CNT_ZERO;
            end else if (cnt_r == FILTER_LAST) begin
               state_nxt_s = ST_RELEASE;
               cnt_nxt_s   = CNT_ZERO;
            end else begin
               state_nxt_s = ST_FILTER;
            end
         end
         ST_RELEASE: begin
            if (!locked_s) begin
               state_nxt_s = ST_WAIT_LOCK;
               cnt_nxt_s   = CNT_ZERO;
            end else if (cnt_r == RELEASE_LAST) begin
               state_nxt_s = ST_RUN;
               cnt_nxt_s   = CNT_ZERO;
            end else begin
               state_nxt_s = ST_RELEASE;
            end
         end
         ST_RUN: begin
            // lock loss outranks a coincident soft reset request
            if (!locked_s) begin
               state_nxt_s = ST_WAIT_LOCK;
               cnt_nxt_s   = CNT_ZERO;
               loss_nxt_s  = sat_inc(loss_cnt_r);
            end else if (soft_reset) begin
               state_nxt_s = ST_RELEASE;
               cnt_nxt_s   = CNT_ZERO;
            end else begin
               state_nxt_s = ST_RUN;
               cnt_nxt_s   = CNT_ZERO;
            end
         end
         default: begin
            state_nxt_s = ST_WAIT_LOCK;
            cnt_nxt_s   = CNT_ZERO;
         end
      endcase
   end

   // State, counters and outputs registered together so outputs track the state exactly
   always_ff @(posedge clkin or negedge reset_n) begin
      if (!reset_n) begin
         state_r       <= ST_WAIT_LOCK;
         cnt_r         <= CNT_ZERO;
         loss_cnt_r    <= LOSS_ZERO;
         pll_rst_r     <= 1'b0;
         sys_reset_n_r <= 1'b0;
         ready_r       <= 1'b0;
      end else begin
         state_r       <= state_nxt_s;
         cnt_r         <= cnt_nxt_s;
         loss_cnt_r    <= loss_nxt_s;
         pll_rst_r     <= (state_nxt_s == ST_PLL_RESET);
         sys_reset_n_r <= (state_nxt_s == ST_RUN);
         ready_r       <= (state_nxt_s == ST_RUN);
      end
   end

   assign pll_rst         = pll_rst_r;
   assign sys_reset_n     = sys_reset_n_r;
   assign ready           = ready_r;
   assign lock_loss_count = loss_cnt_r;

endmodule
